myip_adc_regs: RTL

AXI4-Lite register block for the multi-channel ADC IP, the parametrised successor of the fixed four-register myip_adc slave. It captures samples from the ADC front-end into per-channel data registers and flags new-data and overrun per channel. It exposes control, status and data through a 32-bit AXI4-Lite slave and raises a level interrupt for software. It sits between the ADC sequencer (sample side) and the PS interconnect (bus side).

---
 rtl/myip_adc_pkg.sv | 36 +++
 rtl/myip_adc_axil_slv.sv | 101 ++++++++++
 rtl/myip_adc_regs.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/myip_adc_pkg.sv
// Shared register map, CTRL bit layout, bus constants and helpers for the ADC register block.
package myip_adc_pkg;

  localparam int unsigned CTRL_OFS  = 32'h00;
  localparam int unsigned CH_EN_OFS = 32'h04;
  localparam int unsigned NEW_OFS   = 32'h08;
  localparam int unsigned OVR_OFS   = 32'h0C;
  localparam int unsigned DATA_BASE = 32'h10;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef struct packed {
    logic irq_en;
    logic en;
  } ctrl_t;

  typedef enum logic [1:0] {WR_IDLE, WR_ACK, WR_RESP} wr_state_e;
  typedef enum logic [1:0] {RD_IDLE, RD_ACK, RD_DATA} rd_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

endpackage

// File: rtl/myip_adc_axil_slv.sv
// AXI4-Lite slave handshakes turned into single-cycle register-file write/read strobes.
// Latency: ready one cycle after valid, B/R response the cycle after the handshake edge.
// Backpressure: one write and one read outstanding; no new address accepted until B/R retire.
module myip_adc_axil_slv
  import myip_adc_pkg::*;
#(
  parameter int ADDR_W = 7
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data
);

  wr_state_e wr_st, wr_nxt;
  rd_state_e rd_st, rd_nxt;
  logic [31:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_st   <= WR_IDLE;
      rd_st   <= RD_IDLE;
      rdata_q <= '0;
    end else begin
      wr_st <= wr_nxt;
      rd_st <= rd_nxt;
      if (rd_en) rdata_q <= rd_data;
    end
  end

  always_comb begin
    wr_nxt  = wr_st;
    rd_nxt  = rd_st;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    arready = 1'b0;
    rvalid  = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (wr_st)
      WR_IDLE: if (awvalid && wvalid) wr_nxt = WR_ACK;
      WR_ACK: begin
        awready = 1'b1;
        wready  = 1'b1;
        wr_en   = awvalid && wvalid;
        // A master that withdrew its valids gets no response.
        wr_nxt  = (awvalid && wvalid) ? WR_RESP : WR_IDLE;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) wr_nxt = WR_IDLE;
      end
      default: wr_nxt = WR_IDLE;
    endcase
    case (rd_st)
      RD_IDLE: if (arvalid) rd_nxt = RD_ACK;
      RD_ACK: begin
        arready = 1'b1;
        rd_en   = arvalid;
        rd_nxt  = arvalid ? RD_DATA : RD_IDLE;
      end
      RD_DATA: begin
        rvalid = 1'b1;
        if (rready) rd_nxt = RD_IDLE;
      end
      default: rd_nxt = RD_IDLE;
    endcase
  end

  assign wr_addr = awaddr;
  assign wr_data = wdata;
  assign wr_strb = wstrb;
  assign rd_addr = araddr;
  assign bresp   = RESP_OKAY;
  assign rresp   = RESP_OKAY;
  assign rdata   = rdata_q;

endmodule

// File: rtl/myip_adc_regs.sv
// ADC register block: per-channel sample capture with new/overrun flags behind AXI4-Lite.
// Latency: capture lands on the strobe edge, irq one cycle after NEW/IRQ_EN change.
// Backpressure: none on the sample side; bus side stalls via the slave's single-outstanding rule.
module myip_adc_regs
  import myip_adc_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 12,
  parameter int ADDR_W   = 7,
  localparam int CH_W    = (NUM_CH > 1) ? clog2(NUM_CH) : 1
)(
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic [2:0]          S_AXI_AWPROT,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [31:0]         S_AXI_WDATA,
  input  logic [3:0]          S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic [2:0]          S_AXI_ARPROT,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [31:0]         S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  input  logic                adc_valid,
  input  logic [CH_W-1:0]     adc_ch,
  input  logic [SAMPLE_W-1:0] adc_data,
  output logic                irq
);

  logic              wr_en, rd_en;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [31:0]       wr_data, rd_data;
  logic [3:0]        wr_strb;

  ctrl_t               ctrl_q;
  logic [NUM_CH-1:0]   ch_en_q, new_q, ovr_q;
  logic [NUM_CH-1:0]   cap_hit, rd_clr, ovr_clr;
  logic [SAMPLE_W-1:0] data_q [NUM_CH];
  logic                irq_q;
  logic [31:0]         wr_ofs, rd_ofs, wmask, ctrl_w, ch_en_w;
  logic                sel_ctrl, sel_ch_en, sel_ovr;
  logic                unused_bits;

  myip_adc_axil_slv #(.ADDR_W(ADDR_W)) u_slv (
    .clk     (ACLK),
    .rst     (ARESET),
    .awaddr  (S_AXI_AWADDR),
    .awvalid (S_AXI_AWVALID),
    .awready (S_AXI_AWREADY),
    .wdata   (S_AXI_WDATA),
    .wstrb   (S_AXI_WSTRB),
    .wvalid  (S_AXI_WVALID),
    .wready  (S_AXI_WREADY),
    .bresp   (S_AXI_BRESP),
    .bvalid  (S_AXI_BVALID),
    .bready  (S_AXI_BREADY),
    .araddr  (S_AXI_ARADDR),
    .arvalid (S_AXI_ARVALID),
    .arready (S_AXI_ARREADY),
    .rdata   (S_AXI_RDATA),
    .rresp   (S_AXI_RRESP),
    .rvalid  (S_AXI_RVALID),
    .rready  (S_AXI_RREADY),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign wr_ofs    = 32'(wr_addr) & ~32'h3;
  assign rd_ofs    = 32'(rd_addr) & ~32'h3;
  assign wmask     = strb_mask(wr_strb);
  assign ctrl_w    = (32'(ctrl_q) & ~wmask) | (wr_data & wmask);
  assign ch_en_w   = (32'(ch_en_q) & ~wmask) | (wr_data & wmask);
  assign sel_ctrl  = wr_en && (wr_ofs == CTRL_OFS);
  assign sel_ch_en = wr_en && (wr_ofs == CH_EN_OFS);
  assign sel_ovr   = wr_en && (wr_ofs == OVR_OFS);

  // Strobe gating uses register state before any same-cycle CTRL/CH_EN write.
  always_comb begin
    cap_hit = '0;
    rd_clr  = '0;
    ovr_clr = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cap_hit[k] = adc_valid && ctrl_q.en && ch_en_q[k] && (32'(adc_ch) == 32'(k));
      rd_clr[k]  = rd_en && (rd_ofs == DATA_BASE + 32'(4 * k));
      ovr_clr[k] = sel_ovr && wr_data[k] && wmask[k];
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ctrl_q  <= '0;
      ch_en_q <= '0;
      new_q   <= '0;
      ovr_q   <= '0;
      irq_q   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) data_q[k] <= '0;
    end else begin
      if (sel_ctrl) begin
        ctrl_q.en     <= ctrl_w[CTRL_EN_BIT];
        ctrl_q.irq_en <= ctrl_w[CTRL_IRQ_EN_BIT];
      end
      if (sel_ch_en) ch_en_q <= ch_en_w[NUM_CH-1:0];
      // Sets beat clears; a sample read on the capture edge is consumed, so no overrun.
      new_q <= cap_hit | (new_q & ~rd_clr);
      ovr_q <= (cap_hit & new_q & ~rd_clr) | (ovr_q & ~ovr_clr);
      for (int k = 0; k < NUM_CH; k++)
        if (cap_hit[k]) data_q[k] <= adc_data;
      irq_q <= ctrl_q.irq_en && (|new_q);
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_ofs == CTRL_OFS)  rd_data = 32'(ctrl_q);
    if (rd_ofs == CH_EN_OFS) rd_data = 32'(ch_en_q);
    if (rd_ofs == NEW_OFS)   rd_data = 32'(new_q);
    if (rd_ofs == OVR_OFS)   rd_data = 32'(ovr_q);
    for (int k = 0; k < NUM_CH; k++)
      if (rd_ofs == DATA_BASE + 32'(4 * k)) rd_data = 32'(data_q[k]);
  end

  assign irq = irq_q;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, ctrl_w, ch_en_w, wmask, wr_data};

endmodule
